packet_mem_to_gmii_tx: RTL

- Downstream consumer of the receive packet buffer. Waits for a complete stored packet, fetches its length and bytes through the buffer's read handshake, and transmits it on an 8-bit GMII-style transmit interface.
- Frames are emitted as preamble, SFD, payload, then a mandatory inter-frame gap (IFG).
- Acts as the egress stage of the store-and-forward copy path.

---
 rtl/packet_mem_to_gmii_tx_pkg.sv | 19 +
 rtl/packet_mem_to_gmii_tx_if.sv | 28 ++
 rtl/packet_mem_to_gmii_tx_tx_byte_counter.sv | 35 +++
 rtl/packet_mem_to_gmii_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/packet_mem_to_gmii_tx_pkg.sv
// Shared constants for the packet-buffer to GMII transmit egress stage.
// Holds the TX FSM state encoding and the fixed framing bytes.
package packet_mem_to_gmii_tx_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t lpTX_IDLE     = 3'd0;
    localparam tx_state_t lpTX_LEN      = 3'd1;
    localparam tx_state_t lpTX_PREAMBLE = 3'd2;
    localparam tx_state_t lpTX_SFD      = 3'd3;
    localparam tx_state_t lpTX_DATA     = 3'd4;
    localparam tx_state_t lpTX_DRAIN    = 3'd5;
    localparam tx_state_t lpTX_DROP     = 3'd6;
    localparam tx_state_t lpTX_IFG      = 3'd7;

    localparam logic [7:0] lpPREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] lpSFD_BYTE      = 8'hD5;

endpackage

// File: rtl/packet_mem_to_gmii_tx_if.sv
// Read handshake between the packet buffer and its egress consumer.
// master = consumer issuing reads/pops, slave = buffer.
interface packet_mem_to_gmii_tx_if #(
    parameter int pDATA_WIDTH = 8,
    parameter int pLEN_WIDTH  = 11
);
    logic                   iempty;
    logic [pLEN_WIDTH-1:0]  ilen_pac;
    logic [pDATA_WIDTH-1:0] ird_data;
    logic                   ord_en;
    logic                   olen_pop;

    modport master (
        input  iempty,
        input  ilen_pac,
        input  ird_data,
        output ord_en,
        output olen_pop
    );

    modport slave (
        output iempty,
        output ilen_pac,
        output ird_data,
        input  ord_en,
        input  olen_pop
    );
endinterface

// File: rtl/packet_mem_to_gmii_tx_tx_byte_counter.sv
// Loadable down-counter; zero_o flags that the value after this
// cycle is zero, so callers can act on the final count in time.
module tx_byte_counter #(
    parameter int pWIDTH = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [pWIDTH-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);
    logic [pWIDTH-1:0] cnt_q;
    logic [pWIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - pWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/packet_mem_to_gmii_tx.sv
// Egress stage: pops a stored packet from the buffer and sends it as
// preamble, SFD, payload and inter-frame gap on an 8-bit GMII TX port.
module packet_mem_to_gmii_tx
    import packet_mem_to_gmii_tx_pkg::*;
#(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT),
    parameter int pPREAMBLE_LEN      = 7,
    parameter int pIFG_LEN           = 12
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   ien,
    packet_mem_to_gmii_tx_if.master rd_if,
    output logic                   otx_en,
    output logic [pDATA_WIDTH-1:0] otx_d,
    output logic                   otx_er,
    output logic                   obusy,
    output logic                   olen_err,
    output logic [15:0]            oframe_cnt
);
    localparam int CW = pLEN_WIDTH + 1;
    localparam logic [CW-1:0] MAXL = CW'(pMAX_PACKET_LENGHT);
    localparam logic [CW-1:0] PRE_LOAD = CW'(pPREAMBLE_LEN - 1);
    // IDLE and LEN add two more idle cycles, completing the gap on the wire
    localparam logic [CW-1:0] IFG_LOAD = CW'(pIFG_LEN - 3);

    tx_state_t state_q, state_d;
    logic [pLEN_WIDTH-1:0] rlen_q, rlen_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rlen_ext, req_val;
    logic len_bad, cnt_load, req_zero, tx_zero;

    logic ord_en_q, ord_en_d;
    logic pop_q, pop_d;
    logic txen_q, txen_d;
    logic [pDATA_WIDTH-1:0] txd_q, txd_d;
    logic sel_q, sel_d;
    logic busy_q, busy_d;
    logic err_q, err_d;
    logic [15:0] frame_q, frame_d;

    assign rlen_ext = CW'(rlen_q);
    assign len_bad  = (rlen_ext == '0) || (rlen_ext > MAXL);
    assign req_val  = (rlen_ext > MAXL) ? MAXL : rlen_ext;
    assign cnt_load = (state_q == lpTX_LEN);

    tx_byte_counter #(.pWIDTH(CW)) u_req_cnt (
        .clk_i      (iclk),
        .rst_i      (i_rst),
        .load_i     (cnt_load),
        .load_val_i (req_val),
        .dec_i      (ord_en_q),
        .zero_o     (req_zero)
    );

    tx_byte_counter #(.pWIDTH(CW)) u_tx_cnt (
        .clk_i      (iclk),
        .rst_i      (i_rst),
        .load_i     (cnt_load),
        .load_val_i (rlen_ext),
        .dec_i      (state_q == lpTX_DATA),
        .zero_o     (tx_zero)
    );

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= lpTX_IDLE;
            rlen_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rlen_q  <= rlen_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rlen_d  = rlen_q;
        cnt_d   = cnt_q;
        case (state_q)
            lpTX_IDLE: begin
                if (ien && !rd_if.iempty) begin
                    rlen_d  = rd_if.ilen_pac;
                    state_d = lpTX_LEN;
                end
            end
            lpTX_LEN: begin
                if (len_bad) begin
                    state_d = lpTX_DROP;
                end else begin
                    cnt_d   = PRE_LOAD;
                    state_d = lpTX_PREAMBLE;
                end
            end
            lpTX_PREAMBLE: begin
                if (cnt_q == '0) state_d = lpTX_SFD;
                else cnt_d = cnt_q - CW'(1);
            end
            lpTX_SFD: state_d = lpTX_DATA;
            lpTX_DATA: begin
                if (tx_zero) begin
                    cnt_d   = IFG_LOAD;
                    state_d = lpTX_IFG;
                end
            end
            lpTX_DROP: begin
                if (req_zero) begin
                    cnt_d   = IFG_LOAD;
                    state_d = lpTX_IFG;
                end
            end
            lpTX_IFG: begin
                if (cnt_q == '0) state_d = lpTX_IDLE;
                else cnt_d = cnt_q - CW'(1);
            end
            lpTX_DRAIN: state_d = lpTX_IDLE;
            default:    state_d = lpTX_IDLE;
        endcase
    end

    always_comb begin
        ord_en_d = 1'b0;
        txen_d   = 1'b0;
        txd_d    = '0;
        sel_d    = 1'b0;
        busy_d   = (state_d != lpTX_IDLE);
        pop_d    = (state_q == lpTX_IDLE) && (state_d == lpTX_LEN);
        err_d    = (state_q == lpTX_LEN) && (state_d == lpTX_DROP);
        frame_d  = frame_q;
        case (state_d)
            lpTX_PREAMBLE: begin
                txen_d = 1'b1;
                txd_d  = pDATA_WIDTH'(lpPREAMBLE_BYTE);
            end
            lpTX_SFD: begin
                txen_d   = 1'b1;
                txd_d    = pDATA_WIDTH'(lpSFD_BYTE);
                ord_en_d = !req_zero;
            end
            lpTX_DATA: begin
                txen_d   = 1'b1;
                sel_d    = 1'b1;
                ord_en_d = !req_zero;
            end
            lpTX_DROP: ord_en_d = !req_zero;
            default: ;
        endcase
        if ((state_q == lpTX_DATA) && (state_d == lpTX_IFG)) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            ord_en_q <= 1'b0;
            pop_q    <= 1'b0;
            txen_q   <= 1'b0;
            txd_q    <= '0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            ord_en_q <= ord_en_d;
            pop_q    <= pop_d;
            txen_q   <= txen_d;
            txd_q    <= txd_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    // payload bytes come straight from the buffer's registered read port
    assign otx_d          = sel_q ? rd_if.ird_data : txd_q;
    assign otx_en         = txen_q;
    assign otx_er         = 1'b0;
    assign obusy          = busy_q;
    assign olen_err       = err_q;
    assign oframe_cnt     = frame_q;
    assign rd_if.ord_en   = ord_en_q;
    assign rd_if.olen_pop = pop_q;

endmodule
